// File: rtl/servant_wb_initiator.sv
// servant_wb_initiator
//   Turns one command (read or write) into one classic Wishbone cycle and
//   returns exactly one response for it. A transaction that sees no ack within
//   TIMEOUT bus cycles is closed with an error response.
//
// Handshakes (both directions, strict valid/ready):
//   A transfer happens on a rising edge where valid and ready are both high.
//   The producer holds valid and its payload until that edge. Ready never
//   depends combinationally on valid. All outputs come straight from flops.
//
// Ports
//   i_wb_clk, i_wb_rst        clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready   command handshake; i_cmd_we/adr/dat payload
//   o_rsp_valid/i_rsp_ready   response handshake; o_rsp_dat/o_rsp_err payload
//   o_wb_adr/dat/sel/we/cyc   Wishbone initiator outputs
//   i_wb_rdt/i_wb_ack         Wishbone read data and acknowledge
//   o_dbg_state               current FSM state (0 idle, 1 bus, 2 resp)
module servant_wb_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_we,
  input  logic [31:0] i_cmd_adr,
  input  logic [31:0] i_cmd_dat,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_dat,
  output logic        o_rsp_err,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Last wait-count value before the timeout fires; the cycle count while
  // o_wb_cyc is high therefore never exceeds TIMEOUT.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        wb_cyc_q, wb_cyc_d;
  logic        wb_we_q, wb_we_d;
  logic [31:0] wb_adr_q, wb_adr_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    wb_cyc_d    = wb_cyc_q;
    wb_we_d     = wb_we_q;
    wb_adr_d    = wb_adr_q;
    wb_dat_d    = wb_dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        // cmd_ready_q is low for one idle cycle after reset; it only comes
        // up here, so ready is registered and independent of valid.
        if (cmd_ready_q && i_cmd_valid) begin
          state_d     = S_BUS;
          cmd_ready_d = 1'b0;
          wb_cyc_d    = 1'b1;
          wb_we_d     = i_cmd_we;
          wb_adr_d    = i_cmd_adr;
          wb_dat_d    = i_cmd_dat;
          cnt_d       = 16'd0;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end

      S_BUS: begin
        // Ack takes priority over the timeout, including in the last cycle.
        if (i_wb_ack) begin
          state_d     = S_RESP;
          wb_cyc_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = wb_we_q ? 32'd0 : i_wb_rdt;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_RESP;
          wb_cyc_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_RESP: begin
        // Ready rises on the consume edge, so the consume cycle itself
        // can never also accept a command.
        if (i_rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b0;
        wb_cyc_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      wb_cyc_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_adr_q    <= 32'd0;
      wb_dat_q    <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 32'd0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      wb_cyc_q    <= wb_cyc_d;
      wb_we_q     <= wb_we_d;
      wb_adr_q    <= wb_adr_d;
      wb_dat_q    <= wb_dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_wb_cyc    = wb_cyc_q;
  assign o_wb_we     = wb_we_q;
  assign o_wb_adr    = wb_adr_q;
  assign o_wb_dat    = wb_dat_q;
  assign o_wb_sel    = 4'hF;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_dat   = rsp_dat_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_dbg_state = state_q;

endmodule
